lru_cache_ctrl: RTL

//  Sequencer between one requester (IF or MEM stage) and the LRU tag/value cache plus backing memory.
//  - Accepts one read or write at a time and runs lookup; on a read miss it fetches from memory and fills the cache.
//  - Writes are write-through with write-allocate.
//  - External invalidate requests (writes by another master) are serialised into the cache's invalidate port.

---
 rtl/lru_cache_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lru_cache_ctrl.sv
// Request sequencer between one requester, an external LRU tag/value cache and backing memory.
// Optional read hit/miss statistics counters are enabled by defining LRU_CTRL_STATS_EN.
module lru_cache_ctrl #(
   parameter int TAG_WIDTH   = 8,
   parameter int VALUE_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [TAG_WIDTH-1:0]   cpu_addr,
   input  logic [VALUE_WIDTH-1:0] cpu_wdata,
   output logic                   cpu_ready,
   output logic                   cpu_done,
   output logic [VALUE_WIDTH-1:0] cpu_rdata,
   input  logic                   inv_req,
   input  logic [TAG_WIDTH-1:0]   inv_addr,
   output logic [TAG_WIDTH-1:0]   cache_search_tag,
   output logic [TAG_WIDTH-1:0]   cache_new_tag,
   output logic [VALUE_WIDTH-1:0] cache_new_value,
   output logic                   cache_we,
   output logic                   cache_invalidate,
   input  logic                   cache_miss,
   input  logic [VALUE_WIDTH-1:0] cache_rvalue,
`ifdef LRU_CTRL_STATS_EN
   output logic [15:0]            hit_cnt,
   output logic [15:0]            miss_cnt,
`endif
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [TAG_WIDTH-1:0]   mem_addr,
   output logic [VALUE_WIDTH-1:0] mem_wdata,
   input  logic                   mem_ack,
   input  logic [VALUE_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_MEM_RD, S_FILL, S_MEM_WR, S_UPDATE, S_INV
   } state_t;

   state_t                 r_state, w_next;
   logic [TAG_WIDTH-1:0]   r_addr, r_inv_addr;
   logic [VALUE_WIDTH-1:0] r_wdata, r_mem_data, r_rdata;
   logic                   r_we, r_done, r_hit_pend;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Outputs are decoded from the state register only, so reset clears them asynchronously.
   always_comb begin
      w_next           = r_state;
      cpu_ready        = 1'b0;
      cache_search_tag = '0;
      cache_new_tag    = '0;
      cache_new_value  = '0;
      cache_we         = 1'b0;
      cache_invalidate = 1'b0;
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      mem_addr         = '0;
      mem_wdata        = '0;
      case (r_state)
         S_IDLE: begin
            cpu_ready = 1'b1;
            if (inv_req)      w_next = S_INV;
            else if (cpu_req) w_next = S_LOOKUP;
         end
         S_INV: begin
            cache_search_tag = r_inv_addr;
            cache_invalidate = 1'b1;
            w_next           = S_IDLE;
         end
         S_LOOKUP: begin
            cache_search_tag = r_addr;
            if (r_we)            w_next = S_MEM_WR;
            else if (cache_miss) w_next = S_MEM_RD;
            else                 w_next = S_IDLE;
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = r_addr;
            if (mem_ack) w_next = S_FILL;
         end
         S_FILL: begin
            cache_we        = 1'b1;
            cache_new_tag   = r_addr;
            cache_new_value = r_mem_data;
            w_next          = S_IDLE;
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            if (mem_ack) w_next = S_UPDATE;
         end
         S_UPDATE: begin
            cache_we        = 1'b1;
            cache_new_tag   = r_addr;
            cache_new_value = r_wdata;
            w_next          = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A read hit returns to IDLE at once; r_hit_pend delays its done pulse by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr     <= '0;
         r_inv_addr <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_mem_data <= '0;
         r_rdata    <= '0;
         r_done     <= 1'b0;
         r_hit_pend <= 1'b0;
      end else begin
         r_done     <= r_hit_pend;
         r_hit_pend <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (inv_req) begin
                  r_inv_addr <= inv_addr;
               end else if (cpu_req) begin
                  r_addr  <= cpu_addr;
                  r_we    <= cpu_we;
                  r_wdata <= cpu_wdata;
               end
            end
            S_LOOKUP: begin
               if (!r_we && !cache_miss) begin
                  r_rdata    <= cache_rvalue;
                  r_hit_pend <= 1'b1;
               end
            end
            S_MEM_RD: if (mem_ack) r_mem_data <= mem_rdata;
            S_FILL: begin
               r_rdata <= r_mem_data;
               r_done  <= 1'b1;
            end
            S_UPDATE: r_done <= 1'b1;
            default: ;
         endcase
      end
   end

   assign cpu_done  = r_done;
   assign cpu_rdata = r_rdata;

`ifdef LRU_CTRL_STATS_EN
   logic [15:0] r_hit_cnt, r_miss_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == S_LOOKUP && !r_we) begin
         if (cache_miss) begin
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
         end else begin
            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule
